// File: rtl/wb_arbiter_pkg.sv
// Shared MIPS constants and the write-port grant encoding used by the
// writeback arbiter.
package wb_arbiter_pkg;

  localparam int unsigned DEFAULT_ADDR_SIZE = 5;
  localparam int unsigned DEFAULT_WORD_SIZE = 32;
  localparam int unsigned REG_ZERO          = 0;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_PIPE  = 2'd1,
    GNT_QUEUE = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// 2-entry synchronous FIFO holding long-latency results (address + data)
// awaiting a free register-file write slot.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEFAULT_ADDR_SIZE,
  parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [ADDR_SIZE-1:0] push_addr,
  input  logic [WORD_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_SIZE-1:0] head_addr,
  output logic [WORD_SIZE-1:0] head_data
);

  logic [ADDR_SIZE-1:0] addr_mem [2];
  logic [WORD_SIZE-1:0] data_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Circular pointers: a push+pop at count=1 lands the new entry exactly
  // where rd_ptr moves, so it becomes head at the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: live pipeline writes win, buffered
// long-latency results fill idle slots; tracks busy registers and starvation.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_SIZE    = DEFAULT_ADDR_SIZE,
  parameter int unsigned WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_en,
  input  logic [ADDR_SIZE-1:0]      pipe_addr,
  input  logic [WORD_SIZE-1:0]      pipe_data,
  input  logic                      lu_valid,
  output logic                      lu_ready,
  input  logic [ADDR_SIZE-1:0]      lu_addr,
  input  logic [WORD_SIZE-1:0]      lu_data,
  input  logic                      lu_issue,
  input  logic [ADDR_SIZE-1:0]      lu_issue_addr,
  output logic [(1<<ADDR_SIZE)-1:0] busy,
  output logic                      stall_req,
  output logic                      rd_en,
  output logic [ADDR_SIZE-1:0]      rd_addr,
  output logic [WORD_SIZE-1:0]      rd_data
);

  localparam int unsigned NREG = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] ZERO_ADDR = ADDR_SIZE'(REG_ZERO);

  grant_e               grant;
  logic                 live;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 single;
  logic [ADDR_SIZE-1:0] head_addr;
  logic [WORD_SIZE-1:0] head_data;
  logic [NREG-1:0]      busy_q, busy_nxt;
  logic [3:0]           wait_q, wait_nxt;
  logic                 stall_q, stall_nxt;

  wb_fifo #(
    .ADDR_SIZE (ADDR_SIZE),
    .WORD_SIZE (WORD_SIZE)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (lu_addr),
    .push_data (lu_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  assign live     = pipe_en && (pipe_addr != ZERO_ADDR);
  assign lu_ready = !rst && !full;
  // Address-0 results complete the handshake but are never enqueued.
  assign push     = lu_valid && lu_ready && (lu_addr != ZERO_ADDR);
  assign single   = !empty && !full;

  always_comb begin
    grant = GNT_NONE;
    if (!rst) begin
      if (live)        grant = GNT_PIPE;
      else if (!empty) grant = GNT_QUEUE;
    end
  end

  assign pop     = (grant == GNT_QUEUE);
  assign rd_en   = (grant != GNT_NONE);
  assign rd_addr = pop ? head_addr : pipe_addr;
  assign rd_data = pop ? head_data : pipe_data;

  always_comb begin
    busy_nxt = busy_q;
    if (pop) busy_nxt[head_addr] = 1'b0;
    if (lu_issue && (lu_issue_addr != ZERO_ADDR)) busy_nxt[lu_issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // stall_req drops only when the last waiting entry leaves; a second entry
  // that queued behind a starved head keeps the bubble request up.
  always_comb begin
    wait_nxt  = wait_q;
    stall_nxt = stall_q;
    if (empty || pop)       wait_nxt = '0;
    else if (wait_q != '1)  wait_nxt = wait_q + 4'd1;
    if (pop && single)                         stall_nxt = 1'b0;
    else if (wait_nxt >= 4'(STARVE_LIMIT))     stall_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      busy_q  <= busy_nxt;
      wait_q  <= wait_nxt;
      stall_q <= stall_nxt;
    end
  end

  assign busy      = rst ? '0 : busy_q;
  assign stall_req = stall_q && !rst;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued by
// the stimulus and checked in order by an independent monitor.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_en;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic [31:0] busy;
  logic        stall_req;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  wb_arbiter #(
    .ADDR_SIZE    (5),
    .WORD_SIZE    (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_en       (pipe_en),
    .pipe_addr     (pipe_addr),
    .pipe_data     (pipe_data),
    .lu_valid      (lu_valid),
    .lu_ready      (lu_ready),
    .lu_addr       (lu_addr),
    .lu_data       (lu_data),
    .lu_issue      (lu_issue),
    .lu_issue_addr (lu_issue_addr),
    .busy          (busy),
    .stall_req     (stall_req),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_write(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    pipe_en       = 1'b0;
    pipe_addr     = '0;
    pipe_data     = '0;
    lu_valid      = 1'b0;
    lu_addr       = '0;
    lu_data       = '0;
    lu_issue      = 1'b0;
    lu_issue_addr = '0;
  endtask

  // Monitor: every write the DUT presents must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      checks++;
      if (rd_en !== 1'b0 || lu_ready !== 1'b0) begin
        failures++;
        $display("FAIL rst_quiet actual rd_en=%b lu_ready=%b required 0/0", rd_en, lu_ready);
      end
    end else if (rd_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual addr=%0d data=0x%0h required no write", rd_addr, rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rd_addr !== e.a || rd_data !== e.d) begin
          failures++;
          $display("FAIL write actual addr=%0d data=0x%0h required addr=%0d data=0x%0h",
                   rd_addr, rd_data, e.a, e.d);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_stall", 64'(stall_req), 64'h0);
    chk("reset_ready", 64'(lu_ready), 64'h1);
    chk("reset_rd_en", 64'(rd_en), 64'h0);

    // Issue to r8, result returns three cycles later into an idle pipe.
    next_cycle(); lu_issue = 1'b1; lu_issue_addr = 5'd8;
    @(negedge clk); chk("busy8_pre", 64'(busy[8]), 64'h0);
    next_cycle(); lu_issue = 1'b0;
    @(negedge clk); chk("busy8_set", 64'(busy[8]), 64'h1);
    next_cycle();
    next_cycle(); lu_valid = 1'b1; lu_addr = 5'd8; lu_data = 32'hDEADBEEF;
    exp_write(5'd8, 32'hDEADBEEF);
    @(negedge clk); chk("t2_ready", 64'(lu_ready), 64'h1);
    next_cycle(); lu_valid = 1'b0;
    @(negedge clk);
    chk("t2_rd_en", 64'(rd_en), 64'h1);
    chk("busy8_hold", 64'(busy[8]), 64'h1);
    next_cycle();
    @(negedge clk); chk("busy8_clr", 64'(busy[8]), 64'h0);

    // Two queued results starve behind six live pipe writes.
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      pipe_en   = (c < 6);
      pipe_addr = 5'(10 + c);
      pipe_data = 32'h100 + 32'(c);
      lu_valid  = (c < 2);
      lu_addr   = (c == 0) ? 5'd3 : 5'd4;
      lu_data   = (c == 0) ? 32'h33 : 32'h44;
      if (c < 6)  exp_write(5'(10 + c), 32'h100 + 32'(c));
      if (c == 6) exp_write(5'd3, 32'h33);
      if (c == 7) exp_write(5'd4, 32'h44);
      @(negedge clk);
      chk($sformatf("starve_ready_c%0d", c), 64'(lu_ready), 64'((c < 2) || (c >= 7)));
      chk($sformatf("starve_stall_c%0d", c), 64'(stall_req), 64'((c >= 5) && (c <= 7)));
    end
    idle_inputs();

    // Set of busy[5] coincides with the pop that would clear it.
    next_cycle(); lu_issue = 1'b1; lu_issue_addr = 5'd5;
    @(negedge clk);
    next_cycle(); lu_issue = 1'b0;
    lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'h55;
    pipe_en = 1'b1; pipe_addr = 5'd9; pipe_data = 32'h99;
    exp_write(5'd9, 32'h99);
    @(negedge clk); chk("busy5_set", 64'(busy[5]), 64'h1);
    next_cycle(); lu_valid = 1'b0; pipe_en = 1'b0;
    lu_issue = 1'b1; lu_issue_addr = 5'd5;
    exp_write(5'd5, 32'h55);
    @(negedge clk); chk("pop5_rd_addr", 64'(rd_addr), 64'd5);
    next_cycle(); lu_issue = 1'b0;
    @(negedge clk);
    chk("busy5_set_wins", 64'(busy[5]), 64'h1);
    chk("busy5_ready", 64'(lu_ready), 64'h1);

    // Address-0 results are dropped; a pipe write to r0 leaves the slot free.
    next_cycle(); lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hBAD;
    @(negedge clk); chk("addr0_ready", 64'(lu_ready), 64'h1);
    next_cycle(); lu_valid = 1'b0;
    pipe_en = 1'b1; pipe_addr = 5'd0; pipe_data = 32'hBAD0;
    @(negedge clk);
    chk("addr0_no_write", 64'(rd_en), 64'h0);
    chk("addr0_ready2", 64'(lu_ready), 64'h1);
    next_cycle(); pipe_addr = 5'd12; pipe_data = 32'hC;
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h77;
    exp_write(5'd12, 32'hC);
    @(negedge clk);
    next_cycle(); lu_valid = 1'b0; pipe_addr = 5'd0;
    exp_write(5'd7, 32'h77);
    @(negedge clk);
    chk("pipe0_drain_en", 64'(rd_en), 64'h1);
    chk("pipe0_drain_addr", 64'(rd_addr), 64'd7);
    next_cycle(); idle_inputs();
    @(negedge clk); chk("drained_idle", 64'(rd_en), 64'h0);

    // Reset with two results queued and busy[6] set.
    next_cycle(); lu_issue = 1'b1; lu_issue_addr = 5'd6;
    lu_valid = 1'b1; lu_addr = 5'd6; lu_data = 32'h66;
    pipe_en = 1'b1; pipe_addr = 5'd1; pipe_data = 32'h11;
    exp_write(5'd1, 32'h11);
    @(negedge clk);
    next_cycle(); lu_issue = 1'b0;
    lu_addr = 5'd2; lu_data = 32'h22; pipe_data = 32'h12;
    exp_write(5'd1, 32'h12);
    @(negedge clk);
    chk("busy6_set", 64'(busy[6]), 64'h1);
    chk("pre_rst_ready", 64'(lu_ready), 64'h1);
    next_cycle(); idle_inputs(); rst = 1'b1;
    @(negedge clk);
    chk("in_rst_busy", 64'(busy), 64'h0);
    chk("in_rst_stall", 64'(stall_req), 64'h0);
    next_cycle();
    @(negedge clk);
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'h0);
    chk("post_rst_ready", 64'(lu_ready), 64'h1);
    chk("post_rst_stall", 64'(stall_req), 64'h0);
    chk("post_rst_rd_en", 64'(rd_en), 64'h0);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Register-file write-port arbiter for the MIPS core. Shares the single write port between the in-order pipeline writeback stage and a long-latency unit (multi-cycle mul/div, load-miss refill) that returns results out of band. Buffers long-latency results in a 2-entry queue, keeps a per-register busy scoreboard for decode-stage interlocks, and requests a pipeline bubble when a queued result starves.

## Interface
Parameters:
- ADDR_SIZE, 5, register address width; the scoreboard has 2**ADDR_SIZE bits.
- WORD_SIZE, 32, data width.
- STARVE_LIMIT, 4, cycles a queued result may wait before stall_req asserts; legal range is 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_en  in  1  pipeline writeback valid.
- pipe_addr  in  ADDR_SIZE  pipeline destination register.
- pipe_data  in  WORD_SIZE  pipeline result.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  queue can accept a long-latency result.
- lu_addr  in  ADDR_SIZE  long-latency destination register.
- lu_data  in  WORD_SIZE  long-latency result.
- lu_issue  in  1  decode issued a long-latency op this cycle.
- lu_issue_addr  in  ADDR_SIZE  destination of the issued op.
- busy  out  2**ADDR_SIZE  scoreboard; bit n=1 means register n has a pending long-latency write.
- stall_req  out  1  request for the pipeline to insert a writeback bubble.
- rd_en  out  1  register-file write enable.
- rd_addr  out  ADDR_SIZE  register-file write address.
- rd_data  out  WORD_SIZE  register-file write data.

## Operation
- A pipeline write is "live" when pipe_en=1 and pipe_addr!=0. A write with pipe_en=1 and pipe_addr=0 is treated as idle.
- Grant rule, combinational each cycle:
  - A live pipe write always wins: rd_en=1, rd_addr=pipe_addr, rd_data=pipe_data.
  - Otherwise, if the queue is not empty, the queue head is written and popped at the clock edge.
  - Otherwise rd_en=0, and rd_addr/rd_data are don't-care (drive the pipe values).
- Queue:
  - 2-entry FIFO.
  - Push when lu_valid && lu_ready.
  - lu_ready = (count<2), computed from registered state only. There is no same-cycle pop-through; when full, lu_ready=0 even if a pop occurs that cycle.
  - A result with lu_addr=0 is accepted (handshake completes) but discarded: it is not enqueued.
- Scoreboard:
  - lu_issue with lu_issue_addr!=0 sets busy[addr] at the next edge.
  - A queue pop clears busy[head addr].
  - If a set and a clear hit the same register in the same cycle, the set wins.
  - busy[0] is constant 0.
  - Pipe writes never touch busy. WAW ordering is decode's responsibility, enforced via busy.
- Starvation:
  - wait_cnt increments each cycle the queue is non-empty and not popped. It clears on a pop or when the queue is empty.
  - stall_req is registered. It is 1 from the edge at which wait_cnt reaches STARVE_LIMIT until the edge that pops the head.
  - A live pipe write arriving while stall_req=1 still wins. The bubble takes effect whenever the pipeline supplies it.

## Timing
- Pipe path latency is 0 cycles (combinational pass-through).
- Long-latency path: accepted at edge N, written no earlier than cycle N+1.
- busy changes 1 cycle after the lu_issue or pop cycle.
- Reset, while rst=1 and at the first cycle after:
  - queue empty, wait_cnt=0, busy all 0, stall_req=0.
  - lu_ready=0 and rd_en=0 while rst=1.
  - lu_ready=1 in the first cycle after rst falls.
- Reset mid-operation: queued results and busy bits are discarded with no register-file write. The pipeline flushes alongside.
- Simultaneous push and pop with count=1: count stays 1, and the new entry becomes head at the next edge.

## Structure
- Shared MIPS header holds REG_ZERO (0) and the default ADDR_SIZE/WORD_SIZE values. The same constants are used by the regfile and decode.
- One sub-module: wb_fifo, a 2-entry synchronous FIFO exposing push, pop, full, empty, head_addr, head_data.
- Arbitration, scoreboard and starvation counter are implemented in wb_arbiter itself.

## Test plan
- Reset, then idle: busy=0, stall_req=0, lu_ready=1, rd_en=0.
- lu_issue addr 8; 3 cycles later lu_valid addr 8, data 0xDEADBEEF, pipe idle. Expected: next cycle rd_en=1, rd_addr=8, rd_data=0xDEADBEEF; busy[8] 1→0 one cycle later.
- Two lu results accepted (addr 3, then addr 4) while live pipe writes continue for 6 cycles. Expected:
  - lu_ready=0 while full.
  - stall_req=1 once wait_cnt=4.
  - First idle pipe cycle writes addr 3; stall_req stays 1 for addr 4 until its pop.
- Same cycle: lu_issue addr 5 and pop of a head with addr 5. Expected: busy[5] remains 1.
- lu_valid with addr 0, then pipe_en with addr 0. Expected: no rd_en, queue stays empty; the pipe addr-0 cycle drains any pending head.
- rst asserted with 2 entries queued and busy[6]=1. Expected: no write occurs; after reset busy=0, lu_ready=1.
